// File: rtl/matrix_mem_engine.sv
// Moves an n x n row-major matrix between word-wide memory and a MAX_N-stride
// flat buffer, EPW elements per word with the lowest element in the top slice.
module matrix_mem_engine #(
    parameter int ELEM_W = 8,
    parameter int MAX_N  = 5,
    parameter int MEM_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          op,
    input  logic [$clog2(MAX_N+1)-1:0]    size,
    input  logic [ADDR_W-1:0]             base_addr,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [MEM_W-1:0]              mem_rdata,
    output logic [MEM_W-1:0]              mem_wdata,
    output logic                          mem_we,
    input  logic [MAX_N*MAX_N*ELEM_W-1:0] flat_in,
    output logic [MAX_N*MAX_N*ELEM_W-1:0] flat_out,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int EPW    = MEM_W / ELEM_W;
    localparam int FLAT_W = MAX_N * MAX_N * ELEM_W;
    localparam int SZ_W   = $clog2(MAX_N + 1);
    localparam int CNT_W  = $clog2(MAX_N * MAX_N + 1);

    // IDLE wait | LD_REQ address out | LD_CAP capture word | ST_WR write word | FIN done pulse
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LD_REQ = 3'd1;
    localparam logic [2:0] LD_CAP = 3'd2;
    localparam logic [2:0] ST_WR  = 3'd3;
    localparam logic [2:0] FIN    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [SZ_W-1:0]   size_q, size_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  j_q, j_d;
    logic [CNT_W-1:0]  w_q, w_d;
    logic [SZ_W-1:0]   row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [FLAT_W-1:0] flat_out_q, flat_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    int                slot_v  [EPW];
    logic              slot_ok [EPW];
    logic [SZ_W-1:0]   row_nx, col_nx;
    logic [MEM_W-1:0]  wdata;

    // Row/column walk of the current word's slices, so no divide by n is needed.
    always_comb begin
        int r;
        int c;
        int k;
        r = int'(row_q);
        c = int'(col_q);
        k = int'(j_q) * EPW;
        for (int s = 0; s < EPW; s++) begin
            slot_ok[s] = (k + s) < (int'(size_q) * int'(size_q));
            slot_v[s]  = r * MAX_N + c;
            if (slot_ok[s]) begin
                c = c + 1;
                if (c == int'(size_q)) begin
                    c = 0;
                    r = r + 1;
                end
            end
        end
        row_nx = SZ_W'(r);
        col_nx = SZ_W'(c);
    end

    always_comb begin
        wdata = '0;
        for (int s = 0; s < EPW; s++) begin
            if (slot_ok[s]) begin
                wdata[(EPW-1-s)*ELEM_W +: ELEM_W] = flat_in[slot_v[s]*ELEM_W +: ELEM_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        base_d     = base_q;
        j_d        = j_q;
        w_d        = w_q;
        row_d      = row_q;
        col_d      = col_q;
        mem_addr_d = mem_addr_q;
        flat_out_d = flat_out_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    size_d = size;
                    base_d = base_addr;
                    j_d    = '0;
                    row_d  = '0;
                    col_d  = '0;
                    w_d    = CNT_W'((int'(size) * int'(size) + EPW - 1) / EPW);
                    if (size == '0 || int'(size) > MAX_N) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (!op) begin
                        state_d    = LD_REQ;
                        busy_d     = 1'b1;
                        mem_addr_d = base_addr;
                        flat_out_d = '0;
                    end else begin
                        state_d    = ST_WR;
                        busy_d     = 1'b1;
                        mem_addr_d = base_addr;
                    end
                end
            end
            LD_REQ: begin
                state_d = LD_CAP;
                busy_d  = 1'b1;
            end
            LD_CAP: begin
                for (int s = 0; s < EPW; s++) begin
                    if (slot_ok[s]) begin
                        flat_out_d[slot_v[s]*ELEM_W +: ELEM_W] = mem_rdata[(EPW-1-s)*ELEM_W +: ELEM_W];
                    end
                end
                j_d   = j_q + 1'b1;
                row_d = row_nx;
                col_d = col_nx;
                if (j_d < w_q) begin
                    state_d    = LD_REQ;
                    busy_d     = 1'b1;
                    mem_addr_d = base_q + ADDR_W'(j_d);
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            ST_WR: begin
                j_d   = j_q + 1'b1;
                row_d = row_nx;
                col_d = col_nx;
                if (j_d < w_q) begin
                    busy_d     = 1'b1;
                    mem_addr_d = base_q + ADDR_W'(j_d);
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            size_q     <= '0;
            base_q     <= '0;
            j_q        <= '0;
            w_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            mem_addr_q <= '0;
            flat_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            base_q     <= base_d;
            j_q        <= j_d;
            w_q        <= w_d;
            row_q      <= row_d;
            col_q      <= col_d;
            mem_addr_q <= mem_addr_d;
            flat_out_q <= flat_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Write data follows flat_in live, so the caller only has to hold it while busy.
    assign mem_we    = (state_q == ST_WR);
    assign mem_wdata = (state_q == ST_WR) ? wdata : '0;
    assign mem_addr  = mem_addr_q;
    assign flat_out  = flat_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matrix_mem_engine.sv
// Scoreboard bench for matrix_mem_engine: expected writes and completions are
// queued at issue time from a reference model and popped by an output monitor.
module tb_matrix_mem_engine;

    localparam int ELEM_W = 8;
    localparam int MAX_N  = 5;
    localparam int MEM_W  = 16;
    localparam int ADDR_W = 8;
    localparam int EPW    = MEM_W / ELEM_W;
    localparam int FLAT_W = MAX_N * MAX_N * ELEM_W;
    localparam int SZ_W   = $clog2(MAX_N + 1);
    localparam int P2_FW  = 4 * 4 * 8;

    typedef struct {
        int                cyc;
        logic              err;
        logic [FLAT_W-1:0] flat;
        string             name;
    } done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              op = 1'b0;
    logic [SZ_W-1:0]   size = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_rdata;
    logic [MEM_W-1:0]  mem_wdata;
    logic              mem_we;
    logic [FLAT_W-1:0] flat_in = '0;
    logic [FLAT_W-1:0] flat_out;
    logic              busy, done, err;

    matrix_mem_engine dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .size(size),
        .base_addr(base_addr), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .flat_in(flat_in),
        .flat_out(flat_out), .busy(busy), .done(done), .err(err)
    );

    // Second configuration: four elements per word, 4x4 maximum.
    logic             p2_start = 1'b0;
    logic             p2_op = 1'b0;
    logic [2:0]       p2_size = 3'd3;
    logic [7:0]       p2_base = 8'h20;
    logic [7:0]       p2_addr;
    logic [31:0]      p2_rdata;
    logic [31:0]      p2_wdata;
    logic             p2_we;
    logic [P2_FW-1:0] p2_flat_in = '0;
    logic [P2_FW-1:0] p2_flat_out;
    logic             p2_busy, p2_done, p2_err;

    matrix_mem_engine #(.ELEM_W(8), .MAX_N(4), .MEM_W(32), .ADDR_W(8)) dut_p2 (
        .clk(clk), .reset(reset), .start(p2_start), .op(p2_op), .size(p2_size),
        .base_addr(p2_base), .mem_addr(p2_addr), .mem_rdata(p2_rdata),
        .mem_wdata(p2_wdata), .mem_we(p2_we), .flat_in(p2_flat_in),
        .flat_out(p2_flat_out), .busy(p2_busy), .done(p2_done), .err(p2_err)
    );

    always @(posedge clk) begin
        case (p2_addr)
            8'h20:   p2_rdata <= 32'h01020304;
            8'h21:   p2_rdata <= 32'h05060708;
            8'h22:   p2_rdata <= 32'h090A0B0C;
            default: p2_rdata <= 32'hDEADBEEF;
        endcase
    end

    int         p2_we_cnt = 0;
    int         p2_reads = 0;
    logic [7:0] p2_prev_addr = 8'h00;
    always @(negedge clk) begin
        if (p2_we) p2_we_cnt++;
        if (p2_busy && p2_addr != p2_prev_addr) p2_reads++;
        p2_prev_addr = p2_addr;
    end

    // Main memory: read data registered one cycle after the address.
    logic [MEM_W-1:0]  mem     [256];
    logic [MEM_W-1:0]  mdl_mem [256];
    logic              poke_en = 1'b0;
    logic [7:0]        poke_addr = '0;
    logic [MEM_W-1:0]  poke_data = '0;
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (poke_en) mem[poke_addr] <= poke_data;
    end

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    logic [FLAT_W-1:0]        mdl_flat = '0;
    logic [ADDR_W+MEM_W-1:0]  exp_wr [$];
    done_t                    exp_done [$];
    done_t                    mon_d;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h@%0h required=none", mem_wdata, mem_addr);
            end else begin
                chk("mem_write", {mem_addr, mem_wdata}, exp_wr.pop_front());
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_d = exp_done.pop_front();
                chk({mon_d.name, "_done_cycle"}, cyc, mon_d.cyc);
                chk({mon_d.name, "_err"}, err, mon_d.err);
                chk({mon_d.name, "_flat_out"}, flat_out, mon_d.flat);
                chk({mon_d.name, "_busy_at_done"}, busy, 1'b0);
            end
        end
    end

    function automatic logic [FLAT_W-1:0] rand_flat();
        logic [FLAT_W-1:0] r;
        for (int i = 0; i < MAX_N * MAX_N; i++) r[i*ELEM_W +: ELEM_W] = ELEM_W'($urandom);
        return r;
    endfunction

    task automatic poke(input int a, input logic [MEM_W-1:0] d);
        poke_addr = 8'(a);
        poke_data = d;
        poke_en   = 1'b1;
        mdl_mem[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Reference model: element k sits in word k/EPW, slice k%EPW from the top,
    // and in buffer slot (k/n)*MAX_N + k%n.
    task automatic issue_start(input logic o, input int n, input int b,
                               input logic [FLAT_W-1:0] fin, input string nm);
        int nn, w, lat, slot, a, kk;
        done_t d;
        logic [MEM_W-1:0] word;
        nn = n * n;
        w  = (nn + EPW - 1) / EPW;
        d.err  = 1'b0;
        d.name = nm;
        if (n < 1 || n > MAX_N) begin
            d.err = 1'b1;
            lat   = 1;
        end else if (!o) begin
            mdl_flat = '0;
            for (int k = 0; k < nn; k++) begin
                word = mdl_mem[(b + k / EPW) % 256];
                slot = (k / n) * MAX_N + k % n;
                mdl_flat[slot*ELEM_W +: ELEM_W] = ELEM_W'(word >> ((EPW - 1 - k % EPW) * ELEM_W));
            end
            lat = 2 * w + 1;
        end else begin
            for (int j = 0; j < w; j++) begin
                word = '0;
                for (int p = 0; p < EPW; p++) begin
                    kk = j * EPW + p;
                    if (kk < nn) begin
                        slot = (kk / n) * MAX_N + kk % n;
                        word = word | (MEM_W'(fin[slot*ELEM_W +: ELEM_W]) << ((EPW - 1 - p) * ELEM_W));
                    end
                end
                a = (b + j) % 256;
                exp_wr.push_back({a[7:0], word});
                mdl_mem[a] = word;
            end
            lat = w + 1;
        end
        d.flat = mdl_flat;
        flat_in   = fin;
        op        = o;
        size      = SZ_W'(n);
        base_addr = 8'(b);
        start     = 1'b1;
        d.cyc     = cyc + lat;
        exp_done.push_back(d);
        @(negedge clk);
        start     = 1'b0;
        op        = 1'($urandom);
        size      = SZ_W'($urandom);
        base_addr = 8'($urandom);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (exp_done.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_done.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual=pending required=done", nm);
            exp_done.delete();
            exp_wr.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic o, input int n, input int b,
                         input logic [FLAT_W-1:0] fin, input string nm);
        issue_start(o, n, b, fin, nm);
        wait_done(nm);
    endtask

    initial begin
        logic [FLAT_W-1:0] x;
        logic [P2_FW-1:0]  x2;
        int c0, wc, n, r, k;

        for (int a = 0; a < 256; a++) poke(a, MEM_W'($urandom));
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_flat_out", flat_out, '0);

        poke(8'h10, 16'h0102);
        poke(8'h11, 16'h0304);
        issue(1'b0, 2, 8'h10, flat_in, "load2x2");
        x = '0;
        x[0*8 +: 8] = 8'h01;
        x[1*8 +: 8] = 8'h02;
        x[5*8 +: 8] = 8'h03;
        x[6*8 +: 8] = 8'h04;
        chk("load2x2_slots", flat_out, x);

        for (int j = 0; j < 13; j++) poke(1 + j, {8'(2*j + 1), (j == 12) ? 8'hAA : 8'(2*j + 2)});
        issue(1'b0, 5, 8'h01, flat_in, "load5x5");
        x = '0;
        for (int i = 0; i < 25; i++) x[i*8 +: 8] = 8'(i + 1);
        chk("load5x5_slots", flat_out, x);

        x = rand_flat();
        for (int i = 0; i < 9; i++) x[((i / 3) * 5 + i % 3)*8 +: 8] = 8'(i + 1);
        wc = we_cnt;
        issue(1'b1, 3, 8'hFE, x, "store3x3");
        chk("store3x3_we_cycles", we_cnt - wc, 5);
        chk("store3x3_word_fe", mem[8'hFE], 16'h0102);
        chk("store3x3_word_02", mem[8'h02], 16'h0900);

        wc = we_cnt;
        issue(1'b1, 0, 8'h30, rand_flat(), "size0");
        issue(1'b0, 6, 8'h30, flat_in, "size6");
        chk("illegal_no_we", we_cnt - wc, 0);

        issue_start(1'b0, 2, 8'h10, flat_in, "busy_start");
        @(negedge clk);
        start = 1'b1; op = 1'b1; size = 3'd2; base_addr = 8'h40;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        repeat (10) @(negedge clk);

        issue_start(1'b1, 7, 8'h40, flat_in, "fin_start");
        start = 1'b1; op = 1'b1; size = 3'd2; base_addr = 8'h40;
        @(negedge clk);
        start = 1'b0;
        wait_done("fin_start");
        repeat (10) @(negedge clk);

        reset = 1'b1; start = 1'b1; op = 1'b0; size = 3'd2; base_addr = 8'h10;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        mdl_flat = '0;
        @(negedge clk);
        chk("reset_start_busy", busy, 1'b0);
        repeat (10) @(negedge clk);

        wc = we_cnt;
        start = 1'b1; op = 1'b0; size = 3'd5; base_addr = 8'h01;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 1'b1; size = 3'd3; base_addr = 8'h80;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 9) @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_flat = '0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_err", err, 1'b0);
        chk("abort_mem_we", mem_we, 1'b0);
        chk("abort_mem_addr", mem_addr, 8'h00);
        chk("abort_mem_wdata", mem_wdata, 16'h0000);
        chk("abort_flat_out", flat_out, '0);
        repeat (40) @(negedge clk);
        chk("abort_no_we", we_cnt - wc, 0);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            n = (r == 0) ? 0 : (r == 1) ? $urandom_range(6, 7) : $urandom_range(1, 5);
            issue(1'($urandom), n, $urandom_range(0, 255), rand_flat(), "random");
        end
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);

        p2_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        p2_start = 1'b0;
        k = 0;
        while (!p2_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("p2_done_cycle", cyc - c0, 7);
        chk("p2_err", p2_err, 1'b0);
        x2 = '0;
        for (int i = 0; i < 9; i++) x2[((i / 3) * 4 + i % 3)*8 +: 8] = 8'(i + 1);
        chk("p2_flat_out", p2_flat_out, x2);
        chk("p2_reads", p2_reads, 3);
        chk("p2_no_we", p2_we_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
